// File: rtl/shift_pkg.sv
// Shared types and constants for the shifter request path.
package shift_pkg;

  localparam int unsigned SH_DW = 4;
  localparam int unsigned SH_AW = 2;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // One shift request as carried on both sides of the queue.
  typedef struct packed {
    logic [SH_DW-1:0] data;
    logic             dir;
    logic [SH_AW-1:0] amt;
  } shift_req_t;

endpackage

// File: rtl/shift_req_queue_if.sv
// Valid/ready channel carrying one shift_req_t per transfer.
interface shift_req_queue_if;
  import shift_pkg::*;

  logic       valid;
  logic       ready;
  shift_req_t req;

  modport master (output valid, output req, input ready);
  modport slave  (input valid, input req, output ready);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word fall-through read port and flush.
module sync_fifo #(
  parameter  int unsigned WIDTH = 7,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned LW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata_c,
  output logic [LW-1:0]    level,
  output logic             full_c,
  output logic             empty_c
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;

  // Next pointers and level; flush wins over any push or pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      level_d = level_q + LW'(push) - LW'(pop);
    end
  end

  // Pointer and level registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array; contents past the level are don't-care, so no reset.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata_c = mem_q[rd_ptr_q];
  assign level   = level_q;
  assign full_c  = (level_q == LW'(DEPTH));
  assign empty_c = (level_q == '0);

endmodule

// File: rtl/shift_req_queue.sv
// Request buffer in front of the barrel shifter: FIFO plus handshake and issue count.
module shift_req_queue
  import shift_pkg::*;
#(
  parameter  int unsigned DW    = SH_DW,
  parameter  int unsigned AW    = SH_AW,
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned CW    = 8,
  localparam int unsigned LW    = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  shift_req_queue_if.slave    in_if,
  shift_req_queue_if.master   sh_if,
  output logic [LW-1:0]       level,
  output logic [CW-1:0]       issued
);

  localparam int unsigned REQ_W = DW + 1 + AW;

  logic             full_c, empty_c;
  logic             in_ready_c, sh_valid_c;
  logic             push_c, pop_c;
  logic [REQ_W-1:0] head_c;
  logic [CW-1:0]    issued_q, issued_d;

  sync_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .push    (push_c),
    .pop     (pop_c),
    .wdata   (in_if.req),
    .rdata_c (head_c),
    .level   (level),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  // Handshake mapping; ready looks only at occupancy, never at the sink.
  assign in_ready_c  = !rst && !full_c;
  assign sh_valid_c  = !empty_c;
  assign push_c      = in_if.valid && in_ready_c;
  assign pop_c       = sh_valid_c && sh_if.ready;
  assign in_if.ready = in_ready_c;
  assign sh_if.valid = sh_valid_c;
  assign sh_if.req   = sh_valid_c ? shift_req_t'(head_c) : '0;

  // Issue counter: counts pops that are not squashed by flush.
  always_comb begin
    issued_d = issued_q;
    if (pop_c && !flush) issued_d = issued_q + CW'(1);
  end

  // Issue counter register.
  always_ff @(posedge clk) begin
    if (rst) issued_q <= '0;
    else     issued_q <= issued_d;
  end

  assign issued = issued_q;

endmodule

// File: tb/tb_shift_req_queue.sv
// Bench for shift_req_queue: directed table, corner sequences, random vs. queue model.
module tb_shift_req_queue;
  import shift_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 8;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic [LW-1:0] level;
  logic [CW-1:0] issued;

  shift_req_queue_if in_bus ();
  shift_req_queue_if sh_bus ();

  shift_req_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk    (clk),
    .rst    (rst),
    .flush  (flush),
    .in_if  (in_bus),
    .sh_if  (sh_bus),
    .level  (level),
    .issued (issued)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: plain queue of outstanding requests and a wrapping counter.
  shift_req_t mq[$];
  logic [7:0] m_issued = 8'd0;

  // Values observed in the most recent step (before its clock edge).
  logic       obs_rdy, obs_vld;
  shift_req_t obs_req;
  int         obs_lvl, obs_iss;

  typedef struct {
    logic       r, f, iv;
    shift_req_t rq;
    logic       sr;
    logic       e_rdy, e_vld;
    shift_req_t e_req;
    int         e_lvl, e_iss;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic shift_req_t mk(input logic [3:0] d, input logic dr, input logic [1:0] a);
    shift_req_t t;
    t.data = d;
    t.dir  = dr;
    t.amt  = a;
    return t;
  endfunction

  // One cycle: drive on negedge, compare against the model, then advance the model.
  task automatic step(input logic r, input logic f, input logic iv, input shift_req_t rq,
                      input logic sr);
    logic       e_rdy, e_vld, do_pop, do_push;
    shift_req_t e_req;
    @(negedge clk);
    rst = r; flush = f; in_bus.valid = iv; in_bus.req = rq; sh_bus.ready = sr;
    #1;
    e_rdy = !r && (mq.size() < DEPTH);
    e_vld = (mq.size() != 0);
    e_req = e_vld ? mq[0] : '0;
    obs_rdy = in_bus.ready;
    obs_vld = sh_bus.valid;
    obs_req = sh_bus.req;
    obs_lvl = int'(level);
    obs_iss = int'(issued);
    chk("in_ready", 32'(in_bus.ready), 32'(e_rdy));
    chk("sh_valid", 32'(sh_bus.valid), 32'(e_vld));
    chk("sh_req",   32'(sh_bus.req),   32'(e_req));
    chk("level",    32'(level),        32'(mq.size()));
    chk("issued",   32'(issued),       32'(m_issued));
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_issued = 8'd0;
    end else if (f) begin
      mq.delete();
    end else begin
      do_pop  = e_vld && sr;
      do_push = iv && e_rdy;
      if (do_pop) begin
        void'(mq.pop_front());
        m_issued++;
      end
      if (do_push) mq.push_back(rq);
    end
  endtask

  task automatic add(input logic r, input logic f, input logic iv, input shift_req_t rq,
                     input logic sr, input logic e_rdy, input logic e_vld,
                     input shift_req_t e_req, input int e_lvl, input int e_iss);
    vec_t v;
    v.r = r; v.f = f; v.iv = iv; v.rq = rq; v.sr = sr;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_req = e_req; v.e_lvl = e_lvl; v.e_iss = e_iss;
    tbl.push_back(v);
  endtask

  initial begin
    shift_req_t z, a, b, c, d, e, f, g, h, p, rq;
    z = '0;
    a = mk(4'b0001, DIR_LEFT,  2'd2);
    b = mk(4'b1101, DIR_RIGHT, 2'd2);
    c = mk(4'h3, DIR_LEFT,  2'd0);
    d = mk(4'h5, DIR_RIGHT, 2'd1);
    e = mk(4'h8, DIR_RIGHT, 2'd3);
    f = mk(4'hF, DIR_LEFT,  2'd3);
    g = mk(4'hA, DIR_RIGHT, 2'd0);
    h = mk(4'b1011, DIR_LEFT, 2'd1);

    rst = 1'b1; flush = 1'b0; in_bus.valid = 1'b0; in_bus.req = '0; sh_bus.ready = 1'b0;
    repeat (2) @(posedge clk);

    //    r     f     iv    rq sr      rdy   vld   req lvl iss
    add(1'b1, 1'b0, 1'b0, z, 1'b1,   1'b0, 1'b0, z, 0, 0);
    add(1'b0, 1'b0, 1'b1, a, 1'b1,   1'b1, 1'b0, z, 0, 0);
    add(1'b0, 1'b0, 1'b1, b, 1'b1,   1'b1, 1'b1, a, 1, 0);
    add(1'b0, 1'b0, 1'b0, z, 1'b1,   1'b1, 1'b1, b, 1, 1);
    add(1'b0, 1'b0, 1'b0, z, 1'b0,   1'b1, 1'b0, z, 0, 2);
    add(1'b0, 1'b0, 1'b1, c, 1'b0,   1'b1, 1'b0, z, 0, 2);
    add(1'b0, 1'b0, 1'b1, d, 1'b0,   1'b1, 1'b1, c, 1, 2);
    add(1'b0, 1'b0, 1'b1, e, 1'b0,   1'b1, 1'b1, c, 2, 2);
    add(1'b0, 1'b0, 1'b1, f, 1'b0,   1'b1, 1'b1, c, 3, 2);
    add(1'b0, 1'b0, 1'b1, g, 1'b0,   1'b0, 1'b1, c, 4, 2);
    add(1'b0, 1'b0, 1'b1, g, 1'b1,   1'b0, 1'b1, c, 4, 2);
    add(1'b0, 1'b0, 1'b0, z, 1'b1,   1'b1, 1'b1, d, 3, 3);
    add(1'b0, 1'b0, 1'b1, h, 1'b1,   1'b1, 1'b1, e, 2, 4);
    add(1'b0, 1'b0, 1'b0, z, 1'b1,   1'b1, 1'b1, f, 2, 5);
    add(1'b0, 1'b0, 1'b0, z, 1'b1,   1'b1, 1'b1, h, 1, 6);
    add(1'b0, 1'b0, 1'b0, z, 1'b0,   1'b1, 1'b0, z, 0, 7);

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].f, tbl[i].iv, tbl[i].rq, tbl[i].sr);
      chk($sformatf("tbl%0d_rdy", i), 32'(obs_rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_vld", i), 32'(obs_vld), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_req", i), 32'(obs_req), 32'(tbl[i].e_req));
      chk($sformatf("tbl%0d_lvl", i), 32'(obs_lvl), 32'(tbl[i].e_lvl));
      chk($sformatf("tbl%0d_iss", i), 32'(obs_iss), 32'(tbl[i].e_iss));
    end

    // Flush with a concurrent push and pop at level 3.
    step(1'b0, 1'b0, 1'b1, a, 1'b0);
    step(1'b0, 1'b0, 1'b1, b, 1'b0);
    step(1'b0, 1'b0, 1'b1, c, 1'b0);
    step(1'b0, 1'b1, 1'b1, d, 1'b1);
    chk("flush_rdy_during", 32'(obs_rdy), 32'd1);
    chk("flush_lvl_before", 32'(obs_lvl), 32'd3);
    #2;
    chk("flush_level",    32'(level),            32'd0);
    chk("flush_sh_valid", 32'(sh_bus.valid),     32'd0);
    chk("flush_sh_data",  32'(sh_bus.req.data),  32'd0);
    chk("flush_issued",   32'(issued),           32'd7);
    chk("flush_in_ready", 32'(in_bus.ready),     32'd1);

    // Head held for five cycles while the shifter stalls.
    p = mk(4'h6, DIR_RIGHT, 2'd1);
    step(1'b0, 1'b0, 1'b1, p, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 1'b0, z, 1'b0);
      chk($sformatf("hold%0d_req", k), 32'(obs_req), 32'(p));
      chk($sformatf("hold%0d_vld", k), 32'(obs_vld), 32'd1);
      chk($sformatf("hold%0d_iss", k), 32'(obs_iss), 32'd7);
    end
    step(1'b0, 1'b0, 1'b0, z, 1'b1);

    // Counter wrap: 257 pops from reset leave issued at 1.
    step(1'b1, 1'b0, 1'b0, z, 1'b0);
    for (int k = 0; k < 258; k++) begin
      rq = shift_req_t'(7'($urandom));
      step(1'b0, 1'b0, 1'b1, rq, 1'b1);
    end
    #2;
    chk("wrap_issued", 32'(issued), 32'd1);

    // Reset in the middle of traffic.
    step(1'b0, 1'b0, 1'b1, e, 1'b0);
    step(1'b1, 1'b0, 1'b1, f, 1'b1);
    #2;
    chk("rst_level",    32'(level),        32'd0);
    chk("rst_sh_valid", 32'(sh_bus.valid), 32'd0);
    chk("rst_sh_req",   32'(sh_bus.req),   32'd0);
    chk("rst_issued",   32'(issued),       32'd0);
    chk("rst_in_ready", 32'(in_bus.ready), 32'd0);

    // Random traffic against the queue model.
    for (int k = 0; k < 3000; k++) begin
      rq = shift_req_t'(7'($urandom));
      step(($urandom % 200) == 0, ($urandom % 20) == 0, ($urandom % 10) < 6, rq,
           ($urandom % 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
